// File: rtl/instr_mem_sync_pkg.sv
// Shared constants and response type for the synchronous instruction memory.
package instr_mem_sync_pkg;

   localparam int INST_WIDTH = 32;
   localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic                  fault;
   } imem_rsp_t;

endpackage

// File: rtl/instr_mem_sync_imem_array.sv
// Synchronous RAM: one registered read port, one byte-enabled write port.
// Read-first on collision; only the read data register is reset.
module imem_array
   import instr_mem_sync_pkg::*;
#(
   parameter int                     DEPTH     = 1024,
   parameter int                     WIDTH     = INST_WIDTH,
   parameter logic [WIDTH-1:0]       RESET_VAL = NOP_INST,
   localparam int                    AW        = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rd_en_i,
   input  logic [AW-1:0]        rd_addr_i,
   output logic [WIDTH-1:0]     rd_data_o,
   input  logic                 wr_en_i,
   input  logic [AW-1:0]        wr_addr_i,
   input  logic [WIDTH-1:0]     wr_data_i,
   input  logic [WIDTH/8-1:0]   wr_be_i
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int b = 0; b < WIDTH/8; b++) begin
            if (wr_be_i[b]) mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
         end
      end
   end

   // Non-blocking update of mem_q means a same-cycle read sees the old word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      rd_data_q <= RESET_VAL;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Handshaked instruction memory: 1-cycle fetch latency, back-pressure hold, flush.
// Define IMEM_FAULT_EN for misaligned/out-of-range faults and byte-enabled loads.
module instr_mem_sync
   import instr_mem_sync_pkg::*;
#(
   parameter int                    MEM_SIZE   = 1024,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [INST_WIDTH-1:0] RESET_INST = NOP_INST,
   localparam int                   AW         = $clog2(MEM_SIZE)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [INST_WIDTH-1:0]   rsp_inst_o,
   output logic                    rsp_fault_o,
   input  logic                    flush_i,
   input  logic                    ld_we_i,
   input  logic [AW-1:0]           ld_addr_i,
   input  logic [INST_WIDTH-1:0]   ld_data_i,
   input  logic [INST_WIDTH/8-1:0] ld_be_i
);

   logic                    valid_q, valid_d;
   logic                    fault_q, fault_d;
   logic                    accept;
   logic                    req_fault;
   logic [INST_WIDTH/8-1:0] wr_be;
   logic [INST_WIDTH-1:0]   rd_data;
   imem_rsp_t               rsp;

`ifdef IMEM_FAULT_EN
   assign req_fault = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> (AW + 2)) != '0);
   assign wr_be     = ld_be_i;
`else
   logic unused_cfg_bits;
   assign req_fault       = 1'b0;
   assign wr_be           = '1;
   assign unused_cfg_bits = ^{req_addr_i, ld_be_i};
`endif

   assign req_ready_o = !valid_q || rsp_ready_i || flush_i;
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      valid_d = valid_q;
      fault_d = fault_q;
      if (accept) begin
         valid_d = 1'b1;
         fault_d = req_fault;
      end else if (rsp_ready_i || flush_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   // Faulting fetches leave the read register untouched; the output mux substitutes RESET_INST.
   imem_array #(
      .DEPTH     (MEM_SIZE),
      .WIDTH     (INST_WIDTH),
      .RESET_VAL (RESET_INST)
   ) u_array (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rd_en_i   (accept && !req_fault),
      .rd_addr_i (req_addr_i[AW+1:2]),
      .rd_data_o (rd_data),
      .wr_en_i   (ld_we_i),
      .wr_addr_i (ld_addr_i),
      .wr_data_i (ld_data_i),
      .wr_be_i   (wr_be)
   );

   always_comb begin
      rsp.inst  = fault_q ? RESET_INST : rd_data;
      rsp.fault = fault_q;
   end

   assign rsp_valid_o = valid_q;
   assign rsp_inst_o  = rsp.inst;
   assign rsp_fault_o = rsp.fault;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed self-checking bench for instr_mem_sync; follows IMEM_FAULT_EN if defined.
module tb_instr_mem_sync;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_inst_o;
   logic        rsp_fault_o;
   logic        flush_i;
   logic        ld_we_i;
   logic [9:0]  ld_addr_i;
   logic [31:0] ld_data_i;
   logic [3:0]  ld_be_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   instr_mem_sync #(.MEM_SIZE(1024), .ADDR_WIDTH(32)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_inst_o  (rsp_inst_o),
      .rsp_fault_o (rsp_fault_o),
      .flush_i     (flush_i),
      .ld_we_i     (ld_we_i),
      .ld_addr_i   (ld_addr_i),
      .ld_data_i   (ld_data_i),
      .ld_be_i     (ld_be_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      ld_we_i   = 1'b1;
      ld_addr_i = a;
      ld_data_i = d;
      ld_be_i   = be;
      tick();
      ld_we_i   = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b0;
      flush_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; ld_be_i = '0;
      #12;
      chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("rst_inst",  rsp_inst_o, 32'h0000_0013);
      chk("rst_fault", {31'b0, rsp_fault_o}, 32'd0);
      chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
      rst_ni = 1'b1;
      tick();

      load(10'd0, 32'hCAFE_0001, 4'hF);
      load(10'd5, 32'h00A0_0093, 4'hF);
      load(10'd6, 32'h0010_8113, 4'hF);
      load(10'd7, 32'h1111_1111, 4'hF);
      load(10'd8, 32'hFFFF_FFFF, 4'hF);
      load(10'd8, 32'h1234_5678, 4'h1);

      // streaming, 1-cycle latency
      rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h14;
      tick();
      chk("s1_valid0", {31'b0, rsp_valid_o}, 32'd1);
      chk("s1_inst0",  rsp_inst_o, 32'h00A0_0093);
      req_addr_i = 32'h18;
      tick();
      chk("s1_valid1", {31'b0, rsp_valid_o}, 32'd1);
      chk("s1_inst1",  rsp_inst_o, 32'h0010_8113);
      req_valid_i = 1'b0;
      tick();
      chk("pop_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("pop_keep",  rsp_inst_o, 32'h0010_8113);

      // back-pressure hold
      req_valid_i = 1'b1; req_addr_i = 32'h14; rsp_ready_i = 1'b0;
      tick();
      req_addr_i = 32'h18;
      for (int i = 0; i < 3; i++) begin
         chk("hold_ready", {31'b0, req_ready_o}, 32'd0);
         chk("hold_inst",  rsp_inst_o, 32'h00A0_0093);
         chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
         tick();
      end
      rsp_ready_i = 1'b1;
      #1;
      chk("rel_ready", {31'b0, req_ready_o}, 32'd1);
      tick();
      chk("rel_inst",  rsp_inst_o, 32'h0010_8113);
      chk("rel_valid", {31'b0, rsp_valid_o}, 32'd1);

      // flush with redirected fetch
      req_addr_i = 32'h14;
      tick();
      rsp_ready_i = 1'b0; req_valid_i = 1'b0;
      tick();
      chk("fl_held", rsp_inst_o, 32'h00A0_0093);
      flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h18;
      #1;
      chk("fl_ready", {31'b0, req_ready_o}, 32'd1);
      tick();
      chk("fl_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("fl_inst",  rsp_inst_o, 32'h0010_8113);
      req_valid_i = 1'b0;
      tick();
      chk("fl_only", {31'b0, rsp_valid_o}, 32'd0);
      flush_i = 1'b0; rsp_ready_i = 1'b1;

      // write/fetch collision is read-first
      req_valid_i = 1'b1; req_addr_i = 32'h1C;
      ld_we_i = 1'b1; ld_addr_i = 10'd7; ld_data_i = 32'hDEAD_BEEF; ld_be_i = 4'hF;
      tick();
      ld_we_i = 1'b0;
      chk("col_old", rsp_inst_o, 32'h1111_1111);
      tick();
      chk("col_new", rsp_inst_o, 32'hDEAD_BEEF);

      // byte enables, misaligned and out-of-range fetches
      req_addr_i = 32'h20;
      tick();
`ifdef IMEM_FAULT_EN
      chk("be_word", rsp_inst_o, 32'hFFFF_FF78);
`else
      chk("be_word", rsp_inst_o, 32'h1234_5678);
`endif
      req_addr_i = 32'h16;
      tick();
`ifdef IMEM_FAULT_EN
      chk("mis_fault", {31'b0, rsp_fault_o}, 32'd1);
      chk("mis_inst",  rsp_inst_o, 32'h0000_0013);
`else
      chk("mis_fault", {31'b0, rsp_fault_o}, 32'd0);
      chk("mis_inst",  rsp_inst_o, 32'h00A0_0093);
`endif
      req_addr_i = 32'h1000;
      tick();
`ifdef IMEM_FAULT_EN
      chk("oor_fault", {31'b0, rsp_fault_o}, 32'd1);
      chk("oor_inst",  rsp_inst_o, 32'h0000_0013);
`else
      chk("oor_fault", {31'b0, rsp_fault_o}, 32'd0);
      chk("oor_inst",  rsp_inst_o, 32'hCAFE_0001);
`endif
      req_addr_i = 32'h14;
      tick();
      chk("ok_fault", {31'b0, rsp_fault_o}, 32'd0);
      chk("ok_inst",  rsp_inst_o, 32'h00A0_0093);

      // async reset while a response is held
      req_addr_i = 32'h18; rsp_ready_i = 1'b0;
      tick();
      chk("pre_rst_valid", {31'b0, rsp_valid_o}, 32'd1);
      req_valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("arst_inst",  rsp_inst_o, 32'h0000_0013);
      chk("arst_fault", {31'b0, rsp_fault_o}, 32'd0);
      rst_ni = 1'b1;
      tick();
      chk("post_rst_valid", {31'b0, rsp_valid_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
